// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MUL/DIV/DIVU/REM/REMU sequencer
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_next;
  logic [2:0]         op;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   acc, quo, dvs, res_q;
  logic [CNT_W-1:0]   cnt;

  logic               in_is_mul, in_is_div, in_signed, in_fast;
  logic [WIDTH-1:0]   in_fast_res, abs_a, abs_b;
  logic [WIDTH:0]     div_sh, div_diff;
  logic               neg_q, neg_r;
  logic [WIDTH-1:0]   fix_res;

  assign in_is_mul = (funct3 == 3'b000);
  assign in_is_div = funct3[2];
  assign in_signed = in_is_div & ~funct3[0];
  assign in_fast   = ~(in_is_mul | in_is_div) | (in_is_div & (src_b == '0));
  // Divide-by-zero: quotient all ones, remainder is the dividend; unsupported ops give 0.
  assign in_fast_res = ~(in_is_mul | in_is_div) ? '0 :
                       funct3[1]                ? src_a : '1;
  assign abs_a = (in_signed & src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
  assign abs_b = (in_signed & src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

  assign div_sh   = {acc, quo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, dvs};

  // Modulo-2^WIDTH negation makes the signed-overflow case come out right unaided.
  assign neg_q   = (op == 3'b100) & (sign_a ^ sign_b);
  assign neg_r   = (op == 3'b110) & sign_a;
  assign fix_res = (op == 3'b000) ? acc :
                   op[1]          ? (neg_r ? (~acc + 1'b1) : acc) :
                                    (neg_q ? (~quo + 1'b1) : quo);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = in_fast ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      quo    <= '0;
      dvs    <= '0;
      res_q  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op     <= funct3;
            sign_a <= in_signed & src_a[WIDTH-1];
            sign_b <= in_signed & src_b[WIDTH-1];
            acc    <= '0;
            if (in_fast) begin
              res_q <= in_fast_res;
            end else begin
              cnt <= CNT_W'(WIDTH);
              quo <= in_is_mul ? src_b : abs_a;
              dvs <= in_is_mul ? src_a : abs_b;
            end
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (op == 3'b000) begin
            // quo holds the multiplier, dvs the shifting multiplicand.
            if (quo[0]) acc <= acc + dvs;
            dvs <= dvs << 1;
            quo <= quo >> 1;
          end else if (!div_diff[WIDTH]) begin
            acc <= div_diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            acc <= div_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX:     res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy   = (state == CALC) | (state == FIX);
  assign done   = (state == DONE);
  assign result = done ? res_q : '0;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result)
  );

  task check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000:  return a * b;
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      3'b111:  return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] b);
    if (f == 3'b000) return 34;
    if (!f[2] || b == 0) return 1;
    return 34;
  endfunction

  // Drives one request and follows it to done; exp_lat counts negedges after the drive.
  task run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
              input int exp_lat, input bit scramble, input bit keep_start);
    logic [31:0] exp_res;
    int  k;
    bit  got, busy_bad, res_bad, exp_busy;
    exp_res  = ref_result(f, a, b);
    funct3   = f;
    src_a    = a;
    src_b    = b;
    start    = 1'b1;
    k        = 0;
    got      = 0;
    busy_bad = 0;
    res_bad  = 0;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (scramble && k == 5) begin
        funct3 = 3'($urandom);
        src_a  = $urandom;
        src_b  = $urandom;
      end
      exp_busy = (exp_lat >= 34) && (k >= exp_lat - 33) && (k < exp_lat);
      if (busy !== exp_busy) busy_bad = 1;
      if (done === 1'b1) got = 1;
      else if (result !== 32'h0) res_bad = 1;
    end
    check_val({tag, " done"}, 32'(got), 32'd1);
    check_val({tag, " latency"}, 32'(k), 32'(exp_lat));
    check_val({tag, " result"}, result, exp_res);
    check_val({tag, " busy profile ok"}, 32'(busy_bad), 32'd0);
    check_val({tag, " result zero when idle"}, 32'(res_bad), 32'd0);
    if (!keep_start) begin
      start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    bit          stray_done;
    logic [2:0]  f;
    logic [31:0] a, b;

    rst    = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    src_a  = '0;
    src_b  = '0;
    repeat (3) @(negedge clk);
    check_val("reset busy", 32'(busy), 32'd0);
    check_val("reset done", 32'(done), 32'd0);
    check_val("reset result", result, 32'd0);
    rst = 1'b0;

    run_op("mul 7x6", 3'b000, 32'd7, 32'd6, 34, 0, 0);
    run_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 34, 0, 0);
    run_op("rem -7%2", 3'b110, 32'hFFFF_FFF9, 32'd2, 34, 0, 0);
    run_op("divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 34, 0, 0);
    run_op("remu", 3'b111, 32'hFFFF_FFF9, 32'd2, 34, 0, 0);
    check_val("model div -7/2", ref_result(3'b100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    run_op("div0", 3'b100, 32'h1234, 32'd0, 1, 0, 0);
    run_op("divu0", 3'b101, 32'h1234, 32'd0, 1, 0, 0);
    run_op("rem0", 3'b110, 32'h1234, 32'd0, 1, 0, 0);
    run_op("remu0", 3'b111, 32'h1234, 32'd0, 1, 0, 0);
    run_op("unsupported", 3'b001, 32'h1234, 32'd9, 1, 0, 0);
    run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0, 0);
    run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0, 0);
    run_op("mul ovf", 3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0, 0);

    // Reset in the middle of a divide.
    funct3 = 3'b100;
    src_a  = 32'd1000;
    src_b  = 32'd7;
    start  = 1'b1;
    repeat (10) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check_val("midreset busy", 32'(busy), 32'd0);
    check_val("midreset done", 32'(done), 32'd0);
    rst = 1'b0;
    stray_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) stray_done = 1;
    end
    check_val("midreset no done", 32'(stray_done), 32'd0);
    run_op("mul 3x5 after reset", 3'b000, 32'd3, 32'd5, 34, 0, 0);

    // start held through done, operands scrambled mid-CALC.
    run_op("b2b first", 3'b000, 32'd123, 32'd456, 34, 1, 1);
    run_op("b2b second", 3'b101, 32'd1000, 32'd7, 35, 0, 0);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d f%0d", i, f), f, a, b, ref_latency(f, b), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
